gbm_path_gen: RTL and testbench
===============================

Name: gbm_path_gen

Overview:
- Monte Carlo path generator; sits directly upstream of the option pricing array.
- Produces one 12-bit terminal asset price per simulated path using a fixed-point geometric-Brownian-style recurrence.
- Gaussian shocks are approximated by an on-chip 32-bit LFSR and a sum of four bytes (CLT).
- Each terminal price is delivered over a valid/ready handshake; a job runs num_paths paths, then pulses done.

Parameters:
- W_PRICE, 12, price width; must match the pricing input width.
- W_STEPS, 8, width of the num_steps input.
- W_PATHS, 10, width of the num_paths input.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job request; sampled only in IDLE
- s0  in  12  initial price, unsigned integer
- drift  in  8  signed per-step drift, scale 2^-12
- sigma  in  8  unsigned volatility, scale 2^-8
- num_steps  in  8  time steps per path
- num_paths  in  10  paths per job
- seed  in  32  LFSR seed; 0 is replaced by 32'h1
- path  out  12  terminal price of the current path
- path_valid  out  1  path holds a valid result
- path_ready  in  1  downstream accepts path
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: path=0, path_valid=0, busy=0, done=0, state=IDLE, LFSR=32'h1, counters=0.
- Reset mid-job aborts the job. No partial output is issued after reset.
- FSM states: IDLE, LOAD, STEP, EMIT, FIN.
- IDLE, start=1:
  - latch s0, drift, sigma, num_steps, num_paths, seed (seed=0 loads 32'h1);
  - go to LOAD, or to FIN if num_paths=0.
- start while not in IDLE is ignored. Latched parameters are immune to later input changes.
- LOAD (1 cycle): S<=s0_latched, step_cnt<=0. Next state is STEP if num_steps>0, else EMIT.
- STEP (one step per cycle):
  - S<=next(S); LFSR advances once; step_cnt++.
  - After num_steps STEP cycles, go to EMIT.
- LFSR advances only in STEP cycles. Galois update: l<=(l>>1)^(l[0]?32'h80200003:0).
- Shock: z = l[7:0]+l[15:8]+l[23:16]+l[31:24] - 510, signed 11-bit, range -510..510. It uses the LFSR value before the update in that cycle.
- next(S):
  - d = (S*drift)>>>12, using a signed product.
  - v = (S*sigma*z)>>>15, using a signed product of at least 32 bits.
  - Both shifts are arithmetic, i.e. floor.
  - S_next = clamp(S+d+v, 0, 4095), with the sum computed wide enough to avoid overflow.
- EMIT:
  - path=S, path_valid=1.
  - path and path_valid are held stable while path_ready=0.
  - On path_valid&&path_ready: path_cnt++. Next state is LOAD if path_cnt+1<num_paths, else FIN.
  - path_valid drops the next cycle.
- FIN (1 cycle): done=1, then IDLE. busy=0 from the IDLE cycle on.
- Latency per path: 1 + num_steps + 1 cycles to first path_valid assertion, with no back-pressure.
- Throughput: one path per num_steps+2 cycles when path_ready is tied high.
- Same seed and same parameters give a bit-identical output sequence.
- path_valid never asserts outside EMIT.
- done never coincides with path_valid.

Test Plan:
- sigma=0, drift=0, s0=1234, num_steps=16, num_paths=3, ready=1 -> three outputs of 1234, spaced 18 cycles apart; done one cycle after the third handshake.
- sigma=0, drift=+64, s0=1024, num_steps=4 -> path=1088 (1040, 1056, 1072, 1088); first path_valid on the 6th cycle after the start cycle.
- Saturation: sigma=0, drift=127, s0=4000, num_steps=10 -> 4095.
- Floor: sigma=0, drift=-128, s0=100, num_steps=200 -> 0.
- num_steps=0 -> path=s0.
- Back-pressure: sigma=40, seed=32'hACE1, path_ready low for 5 cycles in EMIT -> path and path_valid stable over those cycles; sequence matches a reference model; rerun with the same seed is identical.
- Edge cases:
  - num_paths=0 -> no path_valid, done pulses 2 cycles after start.
  - start asserted during STEP -> ignored.
  - rst_n low mid-STEP -> outputs at reset values immediately; next start runs cleanly from the new seed.

Source files
------------

// File: rtl/gbm_path_gen.sv
// Monte Carlo path generator: one terminal price per path from a fixed-point
// geometric-Brownian recurrence driven by an LFSR-based approximate Gaussian shock.
module gbm_path_gen #(
  parameter int unsigned W_PRICE = 12,
  parameter int unsigned W_STEPS = 8,
  parameter int unsigned W_PATHS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_PRICE-1:0] s0,
  input  logic [7:0]         drift,
  input  logic [7:0]         sigma,
  input  logic [W_STEPS-1:0] num_steps,
  input  logic [W_PATHS-1:0] num_paths,
  input  logic [31:0]        seed,
  output logic [W_PRICE-1:0] path,
  output logic               path_valid,
  input  logic               path_ready,
  output logic               busy,
  output logic               done
);

  // Arithmetic width: price * sigma * shock stays well inside this.
  localparam int unsigned WA = W_PRICE + 30;

  typedef enum logic [2:0] {StIdle, StLoad, StStep, StEmit, StFin} state_e;

  state_e state_q, state_d;

  logic [W_PRICE-1:0] s0_q, s0_d;
  logic [W_PRICE-1:0] price_q, price_d;
  logic [7:0]         drift_q, drift_d;
  logic [7:0]         sigma_q, sigma_d;
  logic [W_STEPS-1:0] nsteps_q, nsteps_d;
  logic [W_STEPS-1:0] step_cnt_q, step_cnt_d;
  logic [W_PATHS-1:0] npaths_q, npaths_d;
  logic [W_PATHS-1:0] path_cnt_q, path_cnt_d;
  logic [31:0]        lfsr_q, lfsr_d;

  logic [31:0]          lfsr_next;
  logic [9:0]           byte_sum;
  logic signed [10:0]   z;
  logic signed [WA-1:0] s_w, drift_w, sigma_w, z_w;
  logic signed [WA-1:0] d_prod, v_prod, d_term, v_term, sum;
  logic [W_PRICE-1:0]   price_next;
  logic                 step_last;
  logic                 more_paths;
  logic [W_PATHS:0]     path_cnt_inc;

  // Price recurrence and shock generation, evaluated from the current LFSR value.
  always_comb begin
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    byte_sum  = {2'b00, lfsr_q[7:0]} + {2'b00, lfsr_q[15:8]}
              + {2'b00, lfsr_q[23:16]} + {2'b00, lfsr_q[31:24]};
    z         = $signed({1'b0, byte_sum}) - 11'sd510;

    s_w     = {{(WA-W_PRICE){1'b0}}, price_q};
    drift_w = {{(WA-8){drift_q[7]}}, drift_q};
    sigma_w = {{(WA-8){1'b0}}, sigma_q};
    z_w     = {{(WA-11){z[10]}}, z};

    d_prod = s_w * drift_w;
    v_prod = s_w * sigma_w * z_w;
    // Arithmetic shifts floor toward minus infinity.
    d_term = d_prod >>> 12;
    v_term = v_prod >>> 15;
    sum    = s_w + d_term + v_term;

    if (sum[WA-1]) begin
      price_next = '0;
    end else if (|sum[WA-2:W_PRICE]) begin
      price_next = '1;
    end else begin
      price_next = sum[W_PRICE-1:0];
    end
  end

  assign step_last    = (step_cnt_q + W_STEPS'(1)) == nsteps_q;
  assign path_cnt_inc = {1'b0, path_cnt_q} + (W_PATHS+1)'(1);
  assign more_paths   = path_cnt_inc < {1'b0, npaths_q};
  assign path         = price_q;

  // Next-state logic and decoded status outputs.
  always_comb begin
    state_d    = state_q;
    s0_d       = s0_q;
    price_d    = price_q;
    drift_d    = drift_q;
    sigma_d    = sigma_q;
    nsteps_d   = nsteps_q;
    step_cnt_d = step_cnt_q;
    npaths_d   = npaths_q;
    path_cnt_d = path_cnt_q;
    lfsr_d     = lfsr_q;
    path_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          s0_d       = s0;
          drift_d    = drift;
          sigma_d    = sigma;
          nsteps_d   = num_steps;
          npaths_d   = num_paths;
          lfsr_d     = (seed == 32'h0) ? 32'h1 : seed;
          step_cnt_d = '0;
          path_cnt_d = '0;
          state_d    = (num_paths == '0) ? StFin : StLoad;
        end
      end
      StLoad: begin
        price_d    = s0_q;
        step_cnt_d = '0;
        state_d    = (nsteps_q == '0) ? StEmit : StStep;
      end
      StStep: begin
        price_d    = price_next;
        lfsr_d     = lfsr_next;
        step_cnt_d = step_cnt_q + W_STEPS'(1);
        if (step_last) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        path_valid = 1'b1;
        if (path_ready) begin
          path_cnt_d = path_cnt_q + W_PATHS'(1);
          state_d    = more_paths ? StLoad : StFin;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      s0_q       <= '0;
      price_q    <= '0;
      drift_q    <= '0;
      sigma_q    <= '0;
      nsteps_q   <= '0;
      step_cnt_q <= '0;
      npaths_q   <= '0;
      path_cnt_q <= '0;
      lfsr_q     <= 32'h1;
    end else begin
      state_q    <= state_d;
      s0_q       <= s0_d;
      price_q    <= price_d;
      drift_q    <= drift_d;
      sigma_q    <= sigma_d;
      nsteps_q   <= nsteps_d;
      step_cnt_q <= step_cnt_d;
      npaths_q   <= npaths_d;
      path_cnt_q <= path_cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_gbm_path_gen.sv
// Self-checking bench for gbm_path_gen against an arithmetic reference model.
module tb_gbm_path_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] s0;
  logic [7:0]  drift;
  logic [7:0]  sigma;
  logic [7:0]  num_steps;
  logic [9:0]  num_paths;
  logic [31:0] seed;
  logic [11:0] path;
  logic        path_valid;
  logic        path_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int got_q[$];
  int first_q[$];

  always #5 clk = ~clk;

  gbm_path_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s0        (s0),
    .drift     (drift),
    .sigma     (sigma),
    .num_steps (num_steps),
    .num_paths (num_paths),
    .seed      (seed),
    .path      (path),
    .path_valid(path_valid),
    .path_ready(path_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: plain integer arithmetic over the recurrence, one entry per path.
  task automatic build_model(input int s0v, input int dv, input int sv, input int steps,
                             input int paths, input bit [31:0] sd);
    bit [31:0] l;
    longint    s, z, d, v;
    l = (sd == 32'h0) ? 32'h1 : sd;
    exp_q.delete();
    for (int p = 0; p < paths; p++) begin
      s = s0v;
      for (int k = 0; k < steps; k++) begin
        z = longint'(l[7:0]) + longint'(l[15:8]) + longint'(l[23:16]) + longint'(l[31:24]) - 510;
        d = floor_div(s * dv, 4096);
        v = floor_div(s * sv * z, 32768);
        s = s + d + v;
        if (s < 0) s = 0;
        if (s > 4095) s = 4095;
        l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
      end
      exp_q.push_back(int'(s));
    end
  endtask

  // rmode: 0 ready tied high, 1 random ready, 2 five-cycle stall on the first result.
  task automatic run_job(input logic [11:0] a_s0, input logic [7:0] a_drift,
                         input logic [7:0] a_sigma, input logic [7:0] a_steps,
                         input logic [9:0] a_paths, input logic [31:0] a_seed,
                         input int rmode, input bit poke_start, input int exp_val);
    int   dv, cyc, first_valid, last_hs, done_cyc, stall, n_got, budget;
    bit   prev_stall;
    logic [11:0] prev_path;
    dv = int'(a_drift);
    if (dv > 127) dv = dv - 256;
    build_model(int'(a_s0), dv, int'(a_sigma), int'(a_steps), int'(a_paths), a_seed);
    got_q.delete();
    first_valid = -1;
    last_hs     = -1;
    done_cyc    = -1;
    stall       = 0;
    n_got       = 0;
    prev_stall  = 1'b0;
    prev_path   = '0;
    budget      = (int'(a_paths) + 1) * (int'(a_steps) + 2) * 8 + 40;

    @(posedge clk); #1;
    s0 = a_s0; drift = a_drift; sigma = a_sigma; num_steps = a_steps;
    num_paths = a_paths; seed = a_seed; path_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Latched parameters must not follow the inputs after the start cycle.
    s0 = 12'($urandom); drift = 8'($urandom); sigma = 8'($urandom);
    num_steps = 8'($urandom); num_paths = 10'($urandom); seed = $urandom;

    for (cyc = 1; cyc <= budget; cyc++) begin
      if (cyc == 1) check("busy_running", busy, 1);
      if (poke_start) start = (cyc == 3);
      if (prev_stall) begin
        check("hold_valid", path_valid, 1);
        check("hold_path", path, prev_path);
      end else if (path_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (n_got < exp_q.size()) check("path", path, exp_q[n_got]);
        else check("extra_path", n_got, exp_q.size() - 1);
        if (exp_val >= 0) check("path_const", path, exp_val);
      end
      if (done) begin
        check("done_vs_valid", path_valid, 0);
        check("busy_at_done", busy, 1);
        done_cyc = cyc;
        break;
      end
      case (rmode)
        0: path_ready = 1'b1;
        1: path_ready = 1'($urandom_range(0, 1));
        default: begin
          path_ready = !(path_valid && stall < 5);
          if (path_valid && stall < 5) stall++;
        end
      endcase
      if (path_valid && path_ready) begin
        got_q.push_back(int'(path));
        n_got++;
        last_hs    = cyc;
        prev_stall = 1'b0;
      end else begin
        prev_stall = path_valid;
        prev_path  = path;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    path_ready = 1'b1;

    if (done_cyc < 0) begin
      check("timeout", cyc, -1);
    end else begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      check("path_count", n_got, int'(a_paths));
      if (a_paths == 10'd0) begin
        // Start cycle is the first, FIN the second.
        check("done_no_paths", done_cyc, 1);
        check("no_valid", first_valid, -1);
      end else begin
        check("first_latency", first_valid, int'(a_steps) + 2);
        check("done_after_hs", done_cyc, last_hs + 1);
        if (rmode == 0) check("throughput", last_hs, int'(a_paths) * (int'(a_steps) + 2));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; path_ready = 1'b1;
    s0 = '0; drift = '0; sigma = '0; num_steps = '0; num_paths = '0; seed = '0;
    #23;
    check("rst_path", path, 0);
    check("rst_valid", path_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_job(12'd1234, 8'd0, 8'd0, 8'd16, 10'd3, $urandom, 0, 1'b0, 1234);
    run_job(12'd1024, 8'd64, 8'd0, 8'd4, 10'd1, $urandom, 0, 1'b0, 1088);
    run_job(12'd4000, 8'd127, 8'd0, 8'd10, 10'd1, $urandom, 0, 1'b0, 4095);
    run_job(12'd100, 8'h80, 8'd0, 8'd200, 10'd1, $urandom, 0, 1'b0, 0);
    run_job(12'd777, 8'($urandom), 8'($urandom), 8'd0, 10'd2, $urandom, 1, 1'b0, 777);
    run_job(12'd500, 8'd3, 8'd20, 8'd5, 10'd0, $urandom, 0, 1'b0, -1);
    run_job(12'd2000, 8'd10, 8'd30, 8'd20, 10'd2, $urandom, 0, 1'b1, -1);

    run_job(12'd2048, 8'd5, 8'd40, 8'd12, 10'd3, 32'hACE1, 2, 1'b0, -1);
    first_q = got_q;
    run_job(12'd2048, 8'd5, 8'd40, 8'd12, 10'd3, 32'hACE1, 1, 1'b0, -1);
    check("rerun_len", got_q.size(), first_q.size());
    for (int i = 0; i < first_q.size() && i < got_q.size(); i++) begin
      check("rerun_path", got_q[i], first_q[i]);
    end

    // Abort a job mid-STEP with an asynchronous reset.
    @(posedge clk); #1;
    s0 = 12'd3000; drift = 8'd20; sigma = 8'd60; num_steps = 8'd200; num_paths = 10'd2;
    seed = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_path", path, 0);
    check("abort_valid", path_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(12'd3000, 8'd20, 8'd60, 8'd9, 10'd2, 32'h0, 1, 1'b0, -1);

    for (int j = 0; j < 6; j++) begin
      run_job(12'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 24)),
              10'($urandom_range(1, 4)), $urandom, 1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
